// File: rtl/key_filter_multi.sv
// Multi-key debouncer: per key a two-flop synchroniser and a filter FSM producing
// press/release event pulses, a debounced level and a one-shot long-press pulse.
module key_filter_multi #(
  parameter int NUM_KEYS   = 4,
  parameter int CNT_MAX    = 1_000_000,
  parameter int LONG_MAX   = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_long
);
  localparam int DW = $clog2(CNT_MAX);
  localparam int LW = $clog2(LONG_MAX);
  localparam logic [DW-1:0] DCNT_FULL    = DW'(CNT_MAX - 1);
  localparam logic [LW-1:0] LCNT_TOP     = LW'(LONG_MAX - 1);
  localparam logic          RELEASED_PIN = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } state_e;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_key
    logic          sync1_q, sync2_q;
    logic          pressed;
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic          fired_q, fired_d;
    logic          flag_q, flag_d;
    logic          level_q, level_d;
    logic          long_q, long_d;

    assign pressed  = sync2_q ^ ACTIVE_LOW;
    assign lcnt_inc = (lcnt_q == LCNT_TOP) ? lcnt_q : lcnt_q + {{(LW-1){1'b0}}, 1'b1};

    // Synchroniser resets to the released pin level so no edge is seen after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= RELEASED_PIN;
        sync2_q <= RELEASED_PIN;
      end else begin
        sync1_q <= key_in[i];
        sync2_q <= sync1_q;
      end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        lcnt_q  <= '0;
        fired_q <= 1'b0;
        flag_q  <= 1'b0;
        level_q <= 1'b1;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        lcnt_q  <= lcnt_d;
        fired_q <= fired_d;
        flag_q  <= flag_d;
        level_q <= level_d;
        long_q  <= long_d;
      end
    end

    // Next-state logic; dcnt is cleared on every state change.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      lcnt_d  = lcnt_q;
      fired_d = fired_q;
      flag_d  = 1'b0;
      level_d = level_q;
      long_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_d = FILTER0;
            dcnt_d  = '0;
            lcnt_d  = '0;
            fired_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        FILTER0: begin
          if (!pressed) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_FULL) begin
            state_d = DOWN;
            dcnt_d  = '0;
            flag_d  = 1'b1;
            level_d = 1'b0;
          end else begin
            dcnt_d  = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
          end
        end
        DOWN: begin
          lcnt_d = lcnt_inc;
          if ((lcnt_q == LCNT_TOP) && !fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end else begin
            long_d  = 1'b0;
          end
          if (!pressed) begin
            state_d = FILTER1;
            dcnt_d  = '0;
          end else begin
            state_d = DOWN;
          end
        end
        FILTER1: begin
          lcnt_d = lcnt_inc;
          if (pressed) begin
            state_d = DOWN;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_FULL) begin
            state_d = IDLE;
            dcnt_d  = '0;
            flag_d  = 1'b1;
            level_d = 1'b1;
            fired_d = 1'b0;
          end else begin
            dcnt_d  = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = IDLE;
          dcnt_d  = '0;
          lcnt_d  = '0;
          fired_d = 1'b0;
          level_d = 1'b1;
        end
      endcase
    end

    assign key_flag[i]  = flag_q;
    assign key_state[i] = level_q;
    assign key_long[i]  = long_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi (4 keys, CNT_MAX=8, LONG_MAX=32, active-low).
module tb_key_filter_multi;
  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_flag;
  logic [3:0] key_state;
  logic [3:0] key_long;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] prev_state = 4'hF;

  key_filter_multi #(
    .NUM_KEYS  (4),
    .CNT_MAX   (8),
    .LONG_MAX  (32),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state),
    .key_long (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One segment: hold rst/key_in for ncyc edges; at most one flag and one long pulse.
  typedef struct {
    logic       rst;
    logic [3:0] key;
    int         ncyc;
    int         flag_at;
    logic [3:0] flag_val;
    int         long_at;
    logic [3:0] long_val;
    logic [3:0] state_end;
  } vec_t;

  task automatic check(input string name, input int seg, input int cyc,
                       input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s seg%0d cyc%0d: got %h expected %h", name, seg, cyc, act, exp);
    end
  endtask

  task automatic apply_vec(input int seg, input vec_t v);
    logic [3:0] ef, el, es;
    @(negedge clk);
    rst    = v.rst;
    key_in = v.key;
    for (int c = 0; c < v.ncyc; c++) begin
      @(posedge clk);
      #1;
      ef = (c == v.flag_at) ? v.flag_val : 4'h0;
      el = (c == v.long_at) ? v.long_val : 4'h0;
      es = (v.rst || (v.flag_at >= 0 && c >= v.flag_at)) ? v.state_end : prev_state;
      check("key_flag", seg, c, key_flag, ef);
      check("key_long", seg, c, key_long, el);
      check("key_state", seg, c, key_state, es);
    end
    prev_state = v.state_end;
  endtask

  vec_t vecs[16];
  vec_t hv;
  logic [3:0] ef, el, es;

  initial begin
    rst    = 1'b1;
    key_in = 4'hF;

    vecs[0]  = '{1'b1, 4'hF, 20, -1, 4'h0, -1, 4'h0, 4'hF};  // reset, all released
    vecs[1]  = '{1'b0, 4'hF,  2, -1, 4'h0, -1, 4'h0, 4'hF};
    vecs[2]  = '{1'b0, 4'hE, 20, 10, 4'h1, -1, 4'h0, 4'hE};  // key0 clean press
    vecs[3]  = '{1'b0, 4'hF, 20, 10, 4'h1, -1, 4'h0, 4'hF};  // key0 release
    vecs[4]  = '{1'b0, 4'hD,  5, -1, 4'h0, -1, 4'h0, 4'hF};  // key1 glitch
    vecs[5]  = '{1'b0, 4'hF, 20, -1, 4'h0, -1, 4'h0, 4'hF};
    vecs[6]  = '{1'b0, 4'hB, 20, 10, 4'h4, -1, 4'h0, 4'hB};  // key2 press
    vecs[7]  = '{1'b0, 4'hF,  3, -1, 4'h0, -1, 4'h0, 4'hB};  // release bounce
    vecs[8]  = '{1'b0, 4'hB,  3, -1, 4'h0, -1, 4'h0, 4'hB};
    vecs[9]  = '{1'b0, 4'hF, 20, 10, 4'h4, -1, 4'h0, 4'hF};  // final rise
    vecs[10] = '{1'b0, 4'h7, 60, 10, 4'h8, 42, 4'h8, 4'h7};  // key3 long hold
    vecs[11] = '{1'b0, 4'hF, 20, 10, 4'h8, -1, 4'h0, 4'hF};
    vecs[12] = '{1'b0, 4'h6, 20, 10, 4'h9, -1, 4'h0, 4'h6};  // key0+key3 together
    vecs[13] = '{1'b0, 4'hF,  5, -1, 4'h0, -1, 4'h0, 4'h6};  // into FILTER1
    vecs[14] = '{1'b1, 4'hF,  5, -1, 4'h0, -1, 4'h0, 4'hF};  // reset mid-FILTER1
    vecs[15] = '{1'b0, 4'hF, 20, -1, 4'h0, -1, 4'h0, 4'hF};

    for (int i = 0; i < 16; i++) apply_vec(i, vecs[i]);

    // Long press on key1 with a short release bounce: lcnt keeps running through FILTER1.
    @(negedge clk);
    rst    = 1'b0;
    key_in = 4'hD;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 30) key_in = 4'hF;
        else if (c == 33) key_in = 4'hD;
        else key_in = key_in;
      end
      @(posedge clk);
      #1;
      ef = (c == 10) ? 4'h2 : 4'h0;
      el = (c == 42) ? 4'h2 : 4'h0;
      es = (c >= 10) ? 4'hD : 4'hF;
      check("key_flag", 100, c, key_flag, ef);
      check("key_long", 100, c, key_long, el);
      check("key_state", 100, c, key_state, es);
    end
    prev_state = 4'hD;
    hv = '{1'b0, 4'hF, 20, 10, 4'h2, -1, 4'h0, 4'hF};
    apply_vec(101, hv);

    // Reset during FILTER0 aborts the press with no pulse afterwards.
    hv = '{1'b0, 4'hE,  6, -1, 4'h0, -1, 4'h0, 4'hF};
    apply_vec(102, hv);
    hv = '{1'b1, 4'hE,  3, -1, 4'h0, -1, 4'h0, 4'hF};
    apply_vec(103, hv);
    hv = '{1'b0, 4'hF, 15, -1, 4'h0, -1, 4'h0, 4'hF};
    apply_vec(104, hv);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
